// File: rtl/sram_port_arbiter.sv
// Arbiter that shares one single-port memory between the data side (D) and the instruction side (I).
// Read responses are returned to the requester that issued them, using a tag pipeline that has one stage per cycle of memory latency.
module sram_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  input  logic                d_req,
  input  logic [DATA_W/8-1:0] d_wen,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  output logic                d_gnt,
  output logic                d_rvalid,
  output logic [DATA_W-1:0]   d_rdata,
  input  logic                i_req,
  input  logic [ADDR_W-1:0]   i_addr,
  output logic                i_gnt,
  output logic                i_rvalid,
  output logic [DATA_W-1:0]   i_rdata,
  input  logic                mem_ready,
  output logic                mem_en,
  output logic [DATA_W/8-1:0] mem_wen,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                stallreq_for_mem
);

  logic [3:0]         starve_q, starve_d;
  logic [MEM_LAT-1:0] tag_valid_q, tag_valid_d;
  logic [MEM_LAT-1:0] tag_owner_q, tag_owner_d;
  logic [DATA_W-1:0]  d_hold_q, d_hold_d;
  logic [DATA_W-1:0]  i_hold_q, i_hold_d;

  logic i_prio, d_win, i_win;
  logic push_valid, push_owner;
  logic tail_valid, tail_owner;

  // Once I has been refused STARVE_MAX times in a row, it takes priority over D.
  always_comb begin
    i_prio = i_req & (starve_q == 4'(STARVE_MAX));
    i_win  = ~rst & mem_ready & i_req & (i_prio | ~d_req);
    d_win  = ~rst & mem_ready & d_req & ~i_win;
  end

  assign d_gnt            = d_win;
  assign i_gnt            = i_win;
  assign stallreq_for_mem = ~rst & ((d_req & ~d_win) | (i_req & ~i_win));

  always_comb begin
    mem_en    = 1'b0;
    mem_wen   = '0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (d_win) begin
      mem_en    = 1'b1;
      mem_wen   = d_wen;
      mem_addr  = d_addr;
      mem_wdata = d_wdata;
    end else if (i_win) begin
      mem_en   = 1'b1;
      mem_addr = i_addr;
    end
  end

  always_comb begin
    if (i_req & ~i_win)
      starve_d = (starve_q == 4'(STARVE_MAX)) ? starve_q : starve_q + 4'd1;
    else
      starve_d = 4'd0;
  end

  // An owner bit of 1 marks I. A flush removes every I entry, including the one being pushed this cycle.
  always_comb begin
    push_valid     = (d_win & (d_wen == '0)) | i_win;
    push_owner     = i_win;
    tag_valid_d    = '0;
    tag_owner_d    = '0;
    tag_valid_d[0] = push_valid & ~(flush & push_owner);
    tag_owner_d[0] = push_owner;
    for (int k = 1; k < MEM_LAT; k++) begin
      tag_valid_d[k] = tag_valid_q[k-1] & ~(flush & tag_owner_q[k-1]);
      tag_owner_d[k] = tag_owner_q[k-1];
    end
  end

  // A flushed I entry at the tail is also removed, so it produces no response in the flush cycle.
  always_comb begin
    tail_valid = ~rst & tag_valid_q[MEM_LAT-1];
    tail_owner = tag_owner_q[MEM_LAT-1];
    d_rvalid   = tail_valid & ~tail_owner;
    i_rvalid   = tail_valid & tail_owner & ~flush;
    d_rdata    = d_rvalid ? mem_rdata : d_hold_q;
    i_rdata    = i_rvalid ? mem_rdata : i_hold_q;
    d_hold_d   = d_rvalid ? mem_rdata : d_hold_q;
    i_hold_d   = i_rvalid ? mem_rdata : i_hold_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      starve_q    <= 4'd0;
      tag_valid_q <= '0;
      tag_owner_q <= '0;
      d_hold_q    <= '0;
      i_hold_q    <= '0;
    end else begin
      starve_q    <= starve_d;
      tag_valid_q <= tag_valid_d;
      tag_owner_q <= tag_owner_d;
      d_hold_q    <= d_hold_d;
      i_hold_q    <= i_hold_d;
    end
  end

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Bench for sram_port_arbiter with MEM_LAT=1 and MEM_LAT=3.
// A model that schedules responses by the cycle they are due is compared with the design every cycle; literal checks pin down the model.
module tb_sram_port_arbiter;

  localparam int MAXC = 1024;
  localparam int SMAX = 4;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        mem_ready;
  logic        d_req;
  logic [3:0]  d_wen;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        i_req;
  logic [31:0] i_addr;
  logic [31:0] mem_rdata;

  logic        d_gnt_l1, d_rvalid_l1, i_gnt_l1, i_rvalid_l1, mem_en_l1, stall_l1;
  logic [31:0] d_rdata_l1, i_rdata_l1, mem_addr_l1, mem_wdata_l1;
  logic [3:0]  mem_wen_l1;
  logic        d_gnt_l3, d_rvalid_l3, i_gnt_l3, i_rvalid_l3, mem_en_l3, stall_l3;
  logic [31:0] d_rdata_l3, i_rdata_l3, mem_addr_l3, mem_wdata_l3;
  logic [3:0]  mem_wen_l3;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  bit check_en = 0;

  int          exp_own [2][MAXC];
  logic [31:0] m_d_hold [2];
  logic [31:0] m_i_hold [2];
  int          m_starve = 0;

  logic        e_dg, e_ig, e_men, e_stall;
  logic [3:0]  e_mwen;
  logic [31:0] e_maddr, e_mwdata;

  sram_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1), .STARVE_MAX(SMAX)) u_lat1 (
    .clk(clk), .rst(rst), .flush(flush),
    .d_req(d_req), .d_wen(d_wen), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt_l1), .d_rvalid(d_rvalid_l1), .d_rdata(d_rdata_l1),
    .i_req(i_req), .i_addr(i_addr),
    .i_gnt(i_gnt_l1), .i_rvalid(i_rvalid_l1), .i_rdata(i_rdata_l1),
    .mem_ready(mem_ready), .mem_en(mem_en_l1), .mem_wen(mem_wen_l1),
    .mem_addr(mem_addr_l1), .mem_wdata(mem_wdata_l1), .mem_rdata(mem_rdata),
    .stallreq_for_mem(stall_l1)
  );

  sram_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(3), .STARVE_MAX(SMAX)) u_lat3 (
    .clk(clk), .rst(rst), .flush(flush),
    .d_req(d_req), .d_wen(d_wen), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt_l3), .d_rvalid(d_rvalid_l3), .d_rdata(d_rdata_l3),
    .i_req(i_req), .i_addr(i_addr),
    .i_gnt(i_gnt_l3), .i_rvalid(i_rvalid_l3), .i_rdata(i_rdata_l3),
    .mem_ready(mem_ready), .mem_en(mem_en_l3), .mem_wen(mem_wen_l3),
    .mem_addr(mem_addr_l3), .mem_wdata(mem_wdata_l3), .mem_rdata(mem_rdata),
    .stallreq_for_mem(stall_l3)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic fl, input logic mr,
                               input logic dq, input logic [3:0] dw, input logic [31:0] da,
                               input logic [31:0] dwd, input logic iq, input logic [31:0] ia,
                               input logic [31:0] rd);
    @(posedge clk);
    #1;
    rst = r; flush = fl; mem_ready = mr;
    d_req = dq; d_wen = dw; d_addr = da; d_wdata = dwd;
    i_req = iq; i_addr = ia; mem_rdata = rd;
  endtask

  task automatic idle(input int n);
    for (int j = 0; j < n; j++)
      applyStimulus(0, 0, 1, 0, 4'h0, 32'h0, 32'h0, 0, 32'h0, 32'hA5A50000 + 32'(j));
  endtask

  // Compares one instance against the model, then updates that instance's response schedule and hold values.
  task automatic check_inst(input int k, input int lat,
                            input logic dg, input logic ig, input logic men, input logic [3:0] mw,
                            input logic [31:0] ma, input logic [31:0] mwd, input logic st,
                            input logic dv, input logic [31:0] dr, input logic iv, input logic [31:0] ir);
    int own;
    string p;
    p = $sformatf("lat%0d", lat);
    own = exp_own[k][cyc];
    if (rst || (flush && own == 2)) own = 0;
    checkOutput({p, " d_gnt"}, dg, e_dg);
    checkOutput({p, " i_gnt"}, ig, e_ig);
    checkOutput({p, " mem_en"}, men, e_men);
    checkOutput({p, " mem_wen"}, mw, e_mwen);
    checkOutput({p, " mem_addr"}, ma, e_maddr);
    checkOutput({p, " mem_wdata"}, mwd, e_mwdata);
    checkOutput({p, " stallreq"}, st, e_stall);
    checkOutput({p, " d_rvalid"}, dv, own == 1);
    checkOutput({p, " i_rvalid"}, iv, own == 2);
    checkOutput({p, " d_rdata"}, dr, (own == 1) ? mem_rdata : m_d_hold[k]);
    checkOutput({p, " i_rdata"}, ir, (own == 2) ? mem_rdata : m_i_hold[k]);
    if (own == 1) m_d_hold[k] = mem_rdata;
    if (own == 2) m_i_hold[k] = mem_rdata;
    if (rst) begin
      m_d_hold[k] = 32'h0;
      m_i_hold[k] = 32'h0;
    end
    if (cyc + lat < MAXC) begin
      if (e_dg && d_wen == 4'h0) exp_own[k][cyc+lat] = 1;
      if (e_ig) exp_own[k][cyc+lat] = 2;
    end
    for (int c = cyc; c <= cyc + lat && c < MAXC; c++) begin
      if (rst) exp_own[k][c] = 0;
      else if (flush && exp_own[k][c] == 2) exp_own[k][c] = 0;
    end
  endtask

  // Every cycle, work out the grants and memory port values from the arbitration rules, then compare both instances.
  always @(negedge clk) begin
    if (check_en) begin
      e_ig    = !rst && mem_ready && i_req && ((m_starve == SMAX) || !d_req);
      e_dg    = !rst && mem_ready && d_req && !e_ig;
      e_men   = e_dg || e_ig;
      e_mwen  = e_dg ? d_wen : 4'h0;
      e_maddr = e_dg ? d_addr : (e_ig ? i_addr : 32'h0);
      e_mwdata = e_dg ? d_wdata : 32'h0;
      e_stall = !rst && ((d_req && !e_dg) || (i_req && !e_ig));
      check_inst(0, 1, d_gnt_l1, i_gnt_l1, mem_en_l1, mem_wen_l1, mem_addr_l1, mem_wdata_l1,
                 stall_l1, d_rvalid_l1, d_rdata_l1, i_rvalid_l1, i_rdata_l1);
      check_inst(1, 3, d_gnt_l3, i_gnt_l3, mem_en_l3, mem_wen_l3, mem_addr_l3, mem_wdata_l3,
                 stall_l3, d_rvalid_l3, d_rdata_l3, i_rvalid_l3, i_rdata_l3);
      if (rst) m_starve = 0;
      else if (i_req && !e_ig) m_starve = (m_starve == SMAX) ? SMAX : m_starve + 1;
      else m_starve = 0;
    end
    cyc++;
  end

  initial begin
    for (int k = 0; k < 2; k++) begin
      m_d_hold[k] = 32'h0;
      m_i_hold[k] = 32'h0;
    end
    rst = 1; flush = 0; mem_ready = 1; d_req = 0; d_wen = 0; d_addr = 0; d_wdata = 0;
    i_req = 0; i_addr = 0; mem_rdata = 0;
    @(posedge clk);
    #1 check_en = 1;

    // Reset held while both sides request: nothing may be granted.
    applyStimulus(1, 0, 1, 1, 4'h0, 32'h10, 32'h0, 1, 32'h20, 32'h0);
    @(negedge clk);
    checkOutput("reset d_gnt", d_gnt_l1, 0);
    checkOutput("reset mem_en", mem_en_l1, 0);
    checkOutput("reset stallreq", stall_l1, 0);
    idle(2);

    // A single instruction fetch.
    applyStimulus(0, 0, 1, 0, 4'h0, 32'h0, 32'h0, 1, 32'h100, 32'h0);
    @(negedge clk);
    checkOutput("fetch i_gnt", i_gnt_l1, 1);
    checkOutput("fetch mem_addr", mem_addr_l1, 32'h100);
    checkOutput("fetch stallreq", stall_l1, 0);
    applyStimulus(0, 0, 1, 0, 4'h0, 32'h0, 32'h0, 0, 32'h0, 32'h24020001);
    @(negedge clk);
    checkOutput("fetch i_rvalid", i_rvalid_l1, 1);
    checkOutput("fetch i_rdata", i_rdata_l1, 32'h24020001);
    idle(4);

    // D and I request together: D wins, then I is granted once D drops its request.
    applyStimulus(0, 0, 1, 1, 4'h0, 32'h200, 32'h0, 1, 32'h104, 32'h0);
    @(negedge clk);
    checkOutput("both d_gnt", d_gnt_l1, 1);
    checkOutput("both i_gnt", i_gnt_l1, 0);
    checkOutput("both stallreq", stall_l1, 1);
    applyStimulus(0, 0, 1, 0, 4'h0, 32'h0, 32'h0, 1, 32'h104, 32'h11112222);
    @(negedge clk);
    checkOutput("both d_rvalid", d_rvalid_l1, 1);
    checkOutput("both d_rdata", d_rdata_l1, 32'h11112222);
    checkOutput("both late i_gnt", i_gnt_l1, 1);
    applyStimulus(0, 0, 1, 0, 4'h0, 32'h0, 32'h0, 0, 32'h0, 32'h33334444);
    @(negedge clk);
    checkOutput("both i_rdata", i_rdata_l1, 32'h33334444);
    idle(4);

    // I starves for four cycles and is granted on the fifth; D then regains priority.
    for (int n = 0; n < 4; n++) begin
      applyStimulus(0, 0, 1, 1, 4'h0, 32'h210 + 32'(n), 32'h0, 1, 32'h108, 32'h500 + 32'(n));
      @(negedge clk);
      checkOutput("starve i_gnt refused", i_gnt_l1, 0);
    end
    applyStimulus(0, 0, 1, 1, 4'h0, 32'h220, 32'h0, 1, 32'h108, 32'h600);
    @(negedge clk);
    checkOutput("starve i_gnt", i_gnt_l1, 1);
    checkOutput("starve d_gnt", d_gnt_l1, 0);
    checkOutput("starve stallreq", stall_l1, 1);
    applyStimulus(0, 0, 1, 1, 4'h0, 32'h224, 32'h0, 1, 32'h10C, 32'h700);
    @(negedge clk);
    checkOutput("starve reset d_gnt", d_gnt_l1, 1);
    idle(4);

    // A byte-enabled write: it is passed to the memory port and returns no response.
    applyStimulus(0, 0, 1, 1, 4'b0011, 32'h300, 32'hDEADBEEF, 0, 32'h0, 32'h0);
    @(negedge clk);
    checkOutput("write mem_wen", mem_wen_l1, 4'b0011);
    checkOutput("write mem_addr", mem_addr_l1, 32'h300);
    checkOutput("write mem_wdata", mem_wdata_l1, 32'hDEADBEEF);
    applyStimulus(0, 0, 1, 0, 4'h0, 32'h0, 32'h0, 0, 32'h0, 32'h0);
    @(negedge clk);
    checkOutput("write no d_rvalid", d_rvalid_l1, 0);
    idle(4);

    // Flush with MEM_LAT=3: the I read is dropped, and a D read issued in the flush cycle still returns.
    applyStimulus(0, 0, 1, 0, 4'h0, 32'h0, 32'h0, 1, 32'h400, 32'h0);
    applyStimulus(0, 1, 1, 1, 4'h0, 32'h500, 32'h0, 0, 32'h0, 32'h0);
    @(negedge clk);
    checkOutput("flush d_gnt", d_gnt_l3, 1);
    applyStimulus(0, 0, 1, 0, 4'h0, 32'h0, 32'h0, 0, 32'h0, 32'h12340002);
    applyStimulus(0, 0, 1, 0, 4'h0, 32'h0, 32'h0, 0, 32'h0, 32'h12340003);
    @(negedge clk);
    checkOutput("flush no i_rvalid", i_rvalid_l3, 0);
    applyStimulus(0, 0, 1, 0, 4'h0, 32'h0, 32'h0, 0, 32'h0, 32'hCAFE0001);
    @(negedge clk);
    checkOutput("flush d_rvalid", d_rvalid_l3, 1);
    checkOutput("flush d_rdata", d_rdata_l3, 32'hCAFE0001);
    idle(4);

    // Memory not ready: nothing is granted and the pipeline is stalled.
    applyStimulus(0, 0, 0, 1, 4'h0, 32'h600, 32'h0, 1, 32'h604, 32'h0);
    @(negedge clk);
    checkOutput("notready d_gnt", d_gnt_l1, 0);
    checkOutput("notready i_gnt", i_gnt_l1, 0);
    checkOutput("notready mem_en", mem_en_l1, 0);
    checkOutput("notready stallreq", stall_l1, 1);

    // Reset while a read is outstanding: its response is dropped.
    applyStimulus(0, 0, 1, 1, 4'h0, 32'h700, 32'h0, 0, 32'h0, 32'h0);
    applyStimulus(1, 0, 1, 1, 4'h0, 32'h704, 32'h0, 1, 32'h708, 32'h0);
    @(negedge clk);
    checkOutput("midreset mem_en", mem_en_l3, 0);
    checkOutput("midreset stallreq", stall_l3, 0);
    applyStimulus(0, 0, 1, 0, 4'h0, 32'h0, 32'h0, 0, 32'h0, 32'hBEEF0002);
    applyStimulus(0, 0, 1, 0, 4'h0, 32'h0, 32'h0, 0, 32'h0, 32'hBEEF0003);
    @(negedge clk);
    checkOutput("midreset no d_rvalid", d_rvalid_l3, 0);
    checkOutput("midreset d_rdata", d_rdata_l3, 32'h0);
    idle(3);

    // Mixed traffic, checked cycle by cycle against the model.
    for (int n = 0; n < 80; n++) begin
      applyStimulus(($urandom_range(0, 29) == 0), ($urandom_range(0, 7) == 0),
                    ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                    ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15)),
                    $urandom, $urandom, 1'($urandom_range(0, 1)), $urandom, $urandom);
    end
    idle(5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
